// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: valid/ready execute ALU with a registered result and flag stage.
// CLO/CLZ resolve through an iterative leading-bit scan; every other funct completes on accept.
module alu_pipe_hs #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH),
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             wr_en,
   output logic [TAG_W-1:0] out_tag,
   output logic             zero_f,
   output logic             neg_f,
   output logic             carry_f,
   output logic             ovf_f,
   output logic             illegal_f
);

   // state | meaning
   // IDLE  | accepting ops; single-cycle ops load the output register on the accept edge
   // COUNT | scanning sh from the MSB for the first bit that ends a CLO/CLZ run

   localparam logic [5:0] OP_SLL  = 6'b000000;
   localparam logic [5:0] OP_SRL  = 6'b000010;
   localparam logic [5:0] OP_SRA  = 6'b000011;
   localparam logic [5:0] OP_SLLV = 6'b000100;
   localparam logic [5:0] OP_SRLV = 6'b000110;
   localparam logic [5:0] OP_SRAV = 6'b000111;
   localparam logic [5:0] OP_MOVZ = 6'b001010;
   localparam logic [5:0] OP_MOVN = 6'b001011;
   localparam logic [5:0] OP_CLO  = 6'b011100;
   localparam logic [5:0] OP_CLZ  = 6'b011101;
   localparam logic [5:0] OP_ADD  = 6'b100000;
   localparam logic [5:0] OP_ADDU = 6'b100001;
   localparam logic [5:0] OP_SUB  = 6'b100010;
   localparam logic [5:0] OP_SUBU = 6'b100011;
   localparam logic [5:0] OP_AND  = 6'b100100;
   localparam logic [5:0] OP_OR   = 6'b100101;
   localparam logic [5:0] OP_XOR  = 6'b100110;
   localparam logic [5:0] OP_NOR  = 6'b100111;
   localparam logic [5:0] OP_SLT  = 6'b101010;
   localparam logic [5:0] OP_SLTU = 6'b101011;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } aluStateT;

   aluStateT         state;
   aluStateT         stateNext;
   logic [WIDTH-1:0] shReg;
   logic [SHW:0]     cntReg;

   logic             outValidQ;
   logic [WIDTH-1:0] resultQ;
   logic             wrEnQ;
   logic [TAG_W-1:0] tagQ;
   logic             zeroQ;
   logic             negQ;
   logic             carryQ;
   logic             ovfQ;
   logic             illegalQ;

   logic             inReadyInt;
   logic             accept;
   logic             pop;
   logic             isCountOp;
   logic             countDone;
   logic             countFinish;

   logic [WIDTH:0]   sumExt;
   logic [WIDTH:0]   diffExt;
   logic [WIDTH-1:0] exRes;
   logic             exWr;
   logic             exCarry;
   logic             exOvf;
   logic             exIll;
   logic [WIDTH-1:0] countRes;

   assign inReadyInt = reset_n & (state == IDLE) & (~outValidQ | out_ready) & ~flush;
   assign accept     = in_valid & inReadyInt;
   assign pop        = outValidQ & out_ready;
   assign isCountOp  = (op == OP_CLO) | (op == OP_CLZ);

   // The extra top bit of the unsigned difference is the borrow (a < b).
   assign sumExt  = {1'b0, a} + {1'b0, b};
   assign diffExt = {1'b0, a} - {1'b0, b};

   always_comb begin
      exRes   = '0;
      exWr    = 1'b1;
      exCarry = 1'b0;
      exOvf   = 1'b0;
      exIll   = 1'b0;
      case (op)
         OP_ADD: begin
            exRes   = sumExt[WIDTH-1:0];
            exCarry = sumExt[WIDTH];
            exOvf   = (a[WIDTH-1] == b[WIDTH-1]) & (sumExt[WIDTH-1] != a[WIDTH-1]);
         end
         OP_ADDU: begin
            exRes   = sumExt[WIDTH-1:0];
            exCarry = sumExt[WIDTH];
         end
         OP_SUB: begin
            exRes   = diffExt[WIDTH-1:0];
            exCarry = diffExt[WIDTH];
            exOvf   = (a[WIDTH-1] != b[WIDTH-1]) & (diffExt[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUBU: begin
            exRes   = diffExt[WIDTH-1:0];
            exCarry = diffExt[WIDTH];
         end
         OP_AND:  exRes = a & b;
         OP_OR:   exRes = a | b;
         OP_XOR:  exRes = a ^ b;
         OP_NOR:  exRes = ~(a | b);
         OP_SLT:  exRes = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: exRes = WIDTH'(a < b);
         OP_SLL:  exRes = b << shamt;
         OP_SRL:  exRes = b >> shamt;
         OP_SRA:  exRes = $unsigned($signed(b) >>> shamt);
         OP_SLLV: exRes = b << a[SHW-1:0];
         OP_SRLV: exRes = b >> a[SHW-1:0];
         OP_SRAV: exRes = $unsigned($signed(b) >>> a[SHW-1:0]);
         OP_MOVZ: begin
            exRes = a;
            exWr  = (b == '0);
         end
         OP_MOVN: begin
            exRes = a;
            exWr  = (b != '0);
         end
         OP_CLO, OP_CLZ: exRes = '0;
         default: begin
            exWr  = 1'b0;
            exIll = 1'b1;
         end
      endcase
   end

   // A full-width run never sees a set MSB, so the scan stops after WIDTH cycles instead.
   assign countDone = shReg[WIDTH-1] | (cntReg == (SHW+1)'(WIDTH - 1));
   assign countRes  = shReg[WIDTH-1] ? WIDTH'(cntReg) : WIDTH'(WIDTH);

   always_comb begin
      stateNext   = state;
      countFinish = 1'b0;
      case (state)
         IDLE: begin
            if (accept && isCountOp) stateNext = COUNT;
         end
         COUNT: begin
            if (countDone) begin
               stateNext   = IDLE;
               countFinish = ~flush;
            end
         end
         default: stateNext = IDLE;
      endcase
      if (flush) stateNext = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shReg  <= '0;
         cntReg <= '0;
      end else if (accept && isCountOp) begin
         shReg  <= (op == OP_CLO) ? ~a : a;
         cntReg <= '0;
      end else if (state == COUNT && !countDone) begin
         shReg  <= {shReg[WIDTH-2:0], 1'b0};
         cntReg <= cntReg + (SHW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outValidQ <= 1'b0;
         resultQ   <= '0;
         wrEnQ     <= 1'b0;
         tagQ      <= '0;
         zeroQ     <= 1'b0;
         negQ      <= 1'b0;
         carryQ    <= 1'b0;
         ovfQ      <= 1'b0;
         illegalQ  <= 1'b0;
      end else if (flush) begin
         outValidQ <= 1'b0;
      end else if (accept) begin
         tagQ <= in_tag;
         if (isCountOp) begin
            outValidQ <= 1'b0;
         end else begin
            outValidQ <= 1'b1;
            resultQ   <= exRes;
            wrEnQ     <= exWr;
            zeroQ     <= (exRes == '0);
            negQ      <= exRes[WIDTH-1];
            carryQ    <= exCarry;
            ovfQ      <= exOvf;
            illegalQ  <= exIll;
         end
      end else if (countFinish) begin
         outValidQ <= 1'b1;
         resultQ   <= countRes;
         wrEnQ     <= 1'b1;
         zeroQ     <= (countRes == '0);
         negQ      <= countRes[WIDTH-1];
         carryQ    <= 1'b0;
         ovfQ      <= 1'b0;
         illegalQ  <= 1'b0;
      end else if (pop) begin
         outValidQ <= 1'b0;
      end
   end

   assign in_ready  = inReadyInt;
   assign out_valid = outValidQ;
   assign result    = resultQ;
   assign wr_en     = wrEnQ;
   assign out_tag   = tagQ;
   assign zero_f    = zeroQ;
   assign neg_f     = negQ;
   assign carry_f   = carryQ;
   assign ovf_f     = ovfQ;
   assign illegal_f = illegalQ;

endmodule
